reg4_serial_ctrl: RTL and testbench

Sequencer for the team's 4-bit load/shift register: drives its sel/Din/Din_serie inputs and reads back its Dout to serialize 4-bit words LSB-first onto a single-bit stream. It sits between an upstream producer, which uses a valid/ready handshake, and the register instance, which it owns exclusively. It provides inter-word gap timing, an abort, and a sent-word counter.

---
 rtl/reg4_serial_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_reg4_serial_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/reg4_serial_ctrl.sv
// rtl/reg4_serial_ctrl.sv - sequencer serializing WIDTH-bit words LSB-first through an external load/shift register
//
// Purpose: accepts words from a valid/ready producer, parallel-loads them into
// the owned load/shift register, then shifts them out one bit per cycle on
// ser_out. Optional inter-word gap, synchronous abort, and a wrapping count of
// completed words.
//
// Optional feature: define REG4_SERIAL_CTRL_PARITY_EN to append one even-parity
// bit after the data bits (done then moves to the parity cycle).
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous reset, active-low
//   in_valid       in   producer offers in_data
//   in_data        in   word to serialize
//   in_ready       out  word accepted this cycle (IDLE and no abort)
//   abort          in   synchronous abort of the current word
//   reg_sel        out  register sel (1 = shift, 0 = parallel load)
//   reg_din        out  register parallel data
//   reg_din_serie  out  register serial fill input
//   reg_q          in   register contents
//   ser_out        out  serial data bit (0 when ser_valid=0)
//   ser_valid      out  ser_out carries a bit
//   done           out  final bit cycle of a word
//   busy           out  controller not idle
//   words_sent     out  completed-word count, wraps 255 -> 0
module reg4_serial_ctrl #(
    parameter int   WIDTH      = 4,
    parameter int   GAP_CYCLES = 1,
    parameter logic FILL_BIT   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             abort,
    output logic             reg_sel,
    output logic [WIDTH-1:0] reg_din,
    output logic             reg_din_serie,
    input  logic [WIDTH-1:0] reg_q,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             done,
    output logic             busy,
    output logic [7:0]       words_sent
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

`ifdef REG4_SERIAL_CTRL_PARITY_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_PAR = 2'd2, S_GAP = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_GAP = 2'd3} state_t;
`endif

    state_t          r_state;
    state_t          w_next;
    state_t          w_after_word;
    logic [BW-1:0]   r_bit_cnt;
    logic [GW-1:0]   r_gap_cnt;
    logic [7:0]      r_words_sent;
    logic            w_last_bit;
    logic            w_handshake;
    // Only bit 0 of the register is observed; the upper bits just travel down.
    logic            w_unused_q;

`ifdef REG4_SERIAL_CTRL_PARITY_EN
    logic            r_parity;
`endif

    assign w_unused_q   = ^reg_q[WIDTH-1:1];
    assign w_last_bit   = (r_state == S_SHIFT) && (r_bit_cnt == BIT_LAST);
    assign w_handshake  = (r_state == S_IDLE) && in_valid && !abort;
    assign w_after_word = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
    assign words_sent   = r_words_sent;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; abort overrides both the handshake and end-of-word
    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (in_valid) w_next = S_SHIFT;
`ifdef REG4_SERIAL_CTRL_PARITY_EN
                S_SHIFT: if (w_last_bit) w_next = S_PAR;
                S_PAR:   w_next = w_after_word;
`else
                S_SHIFT: if (w_last_bit) w_next = w_after_word;
`endif
                S_GAP:   if (r_gap_cnt == GAP_LAST) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        in_ready      = 1'b0;
        reg_sel       = 1'b0;
        reg_din       = '0;
        reg_din_serie = 1'b0;
        ser_out       = 1'b0;
        ser_valid     = 1'b0;
        done          = 1'b0;
        busy          = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                // Register reloads in_data every idle edge so the accepted
                // word is already in place on the first SHIFT cycle.
                in_ready = !abort;
                reg_din  = in_data;
            end
            S_SHIFT: begin
                reg_sel       = 1'b1;
                reg_din_serie = FILL_BIT;
                ser_valid     = 1'b1;
                ser_out       = reg_q[0];
`ifndef REG4_SERIAL_CTRL_PARITY_EN
                done          = w_last_bit && !abort;
`endif
            end
`ifdef REG4_SERIAL_CTRL_PARITY_EN
            S_PAR: begin
                ser_valid = 1'b1;
                ser_out   = r_parity;
                done      = !abort;
            end
`endif
            default: ;
        endcase
    end

    // Counters and parity latch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bit_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_words_sent <= '0;
        end else begin
            if ((r_state == S_SHIFT) && !abort && !w_last_bit) begin
                r_bit_cnt <= r_bit_cnt + BW'(1);
            end else begin
                r_bit_cnt <= '0;
            end
            if ((r_state == S_GAP) && !abort && (r_gap_cnt != GAP_LAST)) begin
                r_gap_cnt <= r_gap_cnt + GW'(1);
            end else begin
                r_gap_cnt <= '0;
            end
            if (done) begin
                r_words_sent <= r_words_sent + 8'd1;
            end
        end
    end

`ifdef REG4_SERIAL_CTRL_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_parity <= 1'b0;
        end else if (w_handshake) begin
            r_parity <= ^in_data;
        end
    end
`endif

endmodule

// File: tb/tb_reg4_serial_ctrl.sv
// tb/tb_reg4_serial_ctrl.sv - self-checking bench for reg4_serial_ctrl
module tb_reg4_serial_ctrl;

    localparam int   W    = 4;
    localparam int   GAP  = 1;
    localparam logic FILL = 1'b0;
`ifdef REG4_SERIAL_CTRL_PARITY_EN
    localparam bit   PAR  = 1'b1;
`else
    localparam bit   PAR  = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         abort;
    logic         reg_sel;
    logic [W-1:0] reg_din;
    logic         reg_din_serie;
    logic [W-1:0] reg_q;
    logic         ser_out;
    logic         ser_valid;
    logic         done;
    logic         busy;
    logic [7:0]   words_sent;

    reg4_serial_ctrl #(.WIDTH(W), .GAP_CYCLES(GAP), .FILL_BIT(FILL)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .abort(abort), .reg_sel(reg_sel), .reg_din(reg_din),
        .reg_din_serie(reg_din_serie), .reg_q(reg_q), .ser_out(ser_out),
        .ser_valid(ser_valid), .done(done), .busy(busy), .words_sent(words_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 4-bit load/shift register owned by the controller
    always @(posedge clk) begin
        reg_q <= reg_sel ? {reg_din_serie, reg_q[W-1:1]} : reg_din;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [18:0] got, input logic [18:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: actual=%h required=%h", name, $time, got, exp);
        end
    endtask

    function automatic logic [18:0] pack_dut();
        return {in_ready, busy, ser_valid, ser_out, done, reg_sel, reg_din, reg_din_serie, words_sent};
    endfunction

    function automatic logic [12:0] pack_small();
        return {in_ready, busy, ser_valid, ser_out, done, words_sent};
    endfunction

    // Reference model: an accepted word becomes a queue of future cycle slots
    typedef struct { logic v; logic b; logic d; logic s; } slot_t;
    slot_t      q[$];
    logic [7:0] m_words;
    int         m_total;

    function automatic logic [18:0] model_exp();
        slot_t e;
        if (q.size() != 0) begin
            e = q[0];
            return {1'b0, 1'b1, e.v, e.b, e.d & ~abort, e.s, 4'b0, e.s & FILL, m_words};
        end
        return {~abort, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, in_data, 1'b0, m_words};
    endfunction

    task automatic model_step();
        slot_t e;
        bit    was_idle;
        was_idle = (q.size() == 0);
        if (!was_idle) begin
            e = q.pop_front();
            if (!abort && e.d) begin
                m_words = m_words + 8'd1;
                m_total++;
            end
        end
        if (abort) begin
            q.delete();
        end else if (was_idle && in_valid) begin
            for (int k = 0; k < W; k++) q.push_back('{1'b1, in_data[k], (k == W-1) && !PAR, 1'b1});
            if (PAR) q.push_back('{1'b1, ^in_data, 1'b1, 1'b0});
            for (int g = 0; g < GAP; g++) q.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
        end
    endtask

    task automatic model_cycle(input string name, input logic v, input logic [W-1:0] d, input logic a);
        @(negedge clk);
        in_valid = v; in_data = d; abort = a;
        #1;
        check(name, pack_dut(), model_exp());
        model_step();
    endtask

    // Directed vectors: inputs for one cycle and the outputs expected in it
    typedef struct { logic v; logic [W-1:0] d; logic a; logic [4:0] f; logic [7:0] ws; } vec_t;
    vec_t tbl[$];

    // f = {in_ready, busy, ser_valid, ser_out, done}
    task automatic add(input logic v, input logic [W-1:0] d, input logic a, input logic [4:0] f, input logic [7:0] ws);
        tbl.push_back('{v, d, a, f, ws});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_data = '0; abort = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", pack_dut(), {1'b1, 18'b0});
        reset = 1'b1;

`ifdef REG4_SERIAL_CTRL_PARITY_EN
        add(1, 4'h7, 0, 5'b10000, 0);
        add(0, 4'h0, 0, 5'b01110, 0);
        add(0, 4'h0, 0, 5'b01110, 0);
        add(0, 4'h0, 0, 5'b01110, 0);
        add(0, 4'h0, 0, 5'b01100, 0);
        add(0, 4'h0, 0, 5'b01111, 0);
        add(0, 4'h0, 0, 5'b01000, 1);
        add(1, 4'h6, 0, 5'b10000, 1);
        add(0, 4'h0, 0, 5'b01100, 1);
        add(0, 4'h0, 0, 5'b01110, 1);
        add(0, 4'h0, 0, 5'b01110, 1);
        add(0, 4'h0, 0, 5'b01100, 1);
        add(0, 4'h0, 0, 5'b01101, 1);
        add(0, 4'h0, 0, 5'b01000, 2);
        add(1, 4'hF, 1, 5'b00000, 2);
        add(0, 4'h0, 0, 5'b10000, 2);
        add(1, 4'hF, 0, 5'b10000, 2);
        add(0, 4'h0, 0, 5'b01110, 2);
        add(0, 4'h0, 0, 5'b01110, 2);
        add(0, 4'h0, 0, 5'b01110, 2);
        add(0, 4'h0, 0, 5'b01110, 2);
        add(0, 4'h0, 1, 5'b01100, 2);
        add(0, 4'h0, 0, 5'b10000, 2);
`else
        add(1, 4'hB, 0, 5'b10000, 0);
        add(0, 4'h0, 0, 5'b01110, 0);
        add(0, 4'h0, 0, 5'b01110, 0);
        add(0, 4'h0, 0, 5'b01100, 0);
        add(0, 4'h0, 0, 5'b01111, 0);
        add(0, 4'h0, 0, 5'b01000, 1);
        add(1, 4'hF, 0, 5'b10000, 1);
        add(0, 4'h0, 0, 5'b01110, 1);
        add(0, 4'h0, 0, 5'b01110, 1);
        add(0, 4'h0, 1, 5'b01110, 1);
        add(1, 4'h3, 0, 5'b10000, 1);
        add(1, 4'hC, 0, 5'b01110, 1);
        add(1, 4'hC, 0, 5'b01110, 1);
        add(1, 4'hC, 0, 5'b01100, 1);
        add(1, 4'hC, 0, 5'b01101, 1);
        add(1, 4'hC, 0, 5'b01000, 2);
        add(1, 4'hC, 0, 5'b10000, 2);
        add(0, 4'h0, 0, 5'b01100, 2);
        add(0, 4'h0, 0, 5'b01100, 2);
        add(0, 4'h0, 0, 5'b01110, 2);
        add(0, 4'h0, 0, 5'b01111, 2);
        add(0, 4'h0, 0, 5'b01000, 3);
        add(1, 4'h5, 1, 5'b00000, 3);
        add(0, 4'h0, 0, 5'b10000, 3);
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            in_valid = tbl[i].v; in_data = tbl[i].d; abort = tbl[i].a;
            #1;
            check($sformatf("table[%0d]", i), 19'(pack_small()), 19'({tbl[i].f, tbl[i].ws}));
        end

        // Reset asserted in the middle of a word
        @(negedge clk); in_valid = 1'b1; in_data = 4'hA; abort = 1'b0;
        @(negedge clk); in_valid = 1'b0; in_data = 4'h0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check("reset_mid_shift", pack_dut(), {1'b1, 18'b0});
        #1 reset = 1'b1;
        q.delete(); m_words = 8'd0; m_total = 0;

        // Counter wrap: continuous stream until 256 words complete
        for (int c = 0; c < 256 * 8 && m_total < 256; c++) begin
            model_cycle("wrap_stream", 1'b1, W'($urandom), 1'b0);
        end
        @(negedge clk); in_valid = 1'b0; abort = 1'b0;
        #1 check("wrap_words_sent", 19'(words_sent), 19'(0));
        model_step();

        // Randomized traffic with occasional aborts
        for (int c = 0; c < 3000; c++) begin
            model_cycle("random", $urandom_range(0, 9) < 6, W'($urandom), $urandom_range(0, 19) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
